// File: rtl/cpu_bus_defs.sv
// cpu_bus_defs: shared size/owner encodings and arbiter state codes for the CPU memory bus
package cpu_bus_defs;
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;
    typedef enum logic [1:0] {ARB_IDLE, ARB_HOLD_I, ARB_HOLD_D} arb_state_t;
endpackage

// File: rtl/arb_id_fifo.sv
// arb_id_fifo: in-order owner-ID queue recording which requester each outstanding transaction belongs to
module arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_owner,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head_owner
);
    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [DEPTH-1:0] owners;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return p == PTR_W'(DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction
    assign full = count == CNT_W'(DEPTH);
    assign empty = count == '0;
    assign head_owner = owners[rd_ptr];
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) owners[wr_ptr] <= push_owner;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between fetch and data requesters with in-order response routing.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties instead of fixed data-over-inst priority.
module mem_bus_arbiter
    import cpu_bus_defs::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int CNT_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    arb_state_t state;
    logic full, empty, head_owner, idle_grant, grant, gnt_req, accept, pop;
`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;
    assign idle_grant = (inst_req & data_req) ? ((last_grant == OWN_INST) ? OWN_DATA : OWN_INST)
                                              : (data_req ? OWN_DATA : OWN_INST);
    always_ff @(posedge clk) begin
        if (reset) last_grant <= OWN_INST;
        else if (accept) last_grant <= grant;
    end
`else
    assign idle_grant = data_req ? OWN_DATA : OWN_INST;
`endif
    assign grant = state == ARB_HOLD_I ? OWN_INST : state == ARB_HOLD_D ? OWN_DATA : idle_grant;
    // in IDLE the grant always points at a requesting side, so this also covers inst_req | data_req
    assign gnt_req = grant == OWN_DATA ? data_req : inst_req;
    assign mem_req = gnt_req & ~full;
    assign accept = mem_req & mem_addr_ok;
    assign pop = mem_data_ok & ~empty;
    assign mem_wr = grant == OWN_DATA ? data_wr : 1'b0;
    assign mem_size = grant == OWN_DATA ? data_size : SIZE_W;
    assign mem_wstrb = grant == OWN_DATA ? data_wstrb : 4'b0000;
    assign mem_addr = grant == OWN_DATA ? data_addr : inst_addr;
    assign mem_wdata = grant == OWN_DATA ? data_wdata : 32'h0;
    assign inst_addr_ok = accept & (grant == OWN_INST);
    assign data_addr_ok = accept & (grant == OWN_DATA);
    assign inst_data_ok = pop & (head_owner == OWN_INST);
    assign data_data_ok = pop & (head_owner == OWN_DATA);
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;
    always_ff @(posedge clk) begin
        if (reset) state <= ARB_IDLE;
        else if (state == ARB_IDLE) begin
            if (mem_req & ~mem_addr_ok) state <= grant == OWN_DATA ? ARB_HOLD_D : ARB_HOLD_I;
        end else if (accept | ~gnt_req) state <= ARB_IDLE;
    end
    arb_id_fifo #(.DEPTH(OUTSTANDING), .CNT_W(CNT_W)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(accept),
        .push_owner(grant),
        .pop(pop),
        .full(full),
        .empty(empty),
        .head_owner(head_owner)
    );
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of arbitration, hold, full blocking, ID routing and reset flush
module tb_mem_bus_arbiter;
    logic        clk, reset;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.OUTSTANDING(2), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] owners;
        reset = 1; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 2;
        data_wstrb = 0; data_addr = 0; data_wdata = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        tick(); tick();
        settle();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_addr_ok", {30'b0, inst_addr_ok, data_addr_ok}, 0);
        chk("rst_data_ok", {30'b0, inst_data_ok, data_data_ok}, 0);
        tick();
        reset = 0;
        tick();

        // both request: data first, then inst; responses route in order
        inst_req = 1; inst_addr = 32'h1C000000;
        data_req = 1; data_addr = 32'h100; data_wr = 0; data_size = 2; mem_addr_ok = 1;
        settle();
        chk("t1_mem_addr_d", mem_addr, 32'h100);
        chk("t1_addr_ok_d", {30'b0, inst_addr_ok, data_addr_ok}, 32'b01);
        tick();
        data_req = 0;
        settle();
        chk("t1_mem_addr_i", mem_addr, 32'h1C000000);
        chk("t1_addr_ok_i", {30'b0, inst_addr_ok, data_addr_ok}, 32'b10);
        chk("t1_inst_side", {mem_wr, mem_size, mem_wstrb}, {1'b0, 2'd2, 4'b0000});
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hAAAA;
        settle();
        chk("t1_rsp1_ok", {30'b0, inst_data_ok, data_data_ok}, 32'b01);
        chk("t1_rsp1_data", data_rdata, 32'hAAAA);
        tick();
        mem_rdata = 32'hBBBB;
        settle();
        chk("t1_rsp2_ok", {30'b0, inst_data_ok, data_data_ok}, 32'b10);
        chk("t1_rsp2_data", inst_rdata, 32'hBBBB);
        tick();
        mem_data_ok = 0;

        // store held by mem_addr_ok=0 for 3 cycles while inst also requests
        data_req = 1; data_wr = 1; data_size = 1; data_wstrb = 4'b0011;
        data_addr = 32'h200; data_wdata = 32'h12345678; inst_req = 1; inst_addr = 32'h1C000010;
        for (int c = 0; c < 4; c++) begin
            mem_addr_ok = (c == 3);
            settle();
            chk("t2_addr", mem_addr, 32'h200);
            chk("t2_wdata", mem_wdata, 32'h12345678);
            chk("t2_ctl", {mem_req, mem_wr, mem_size, mem_wstrb}, {1'b1, 1'b1, 2'd1, 4'b0011});
            chk("t2_addr_ok", {30'b0, inst_addr_ok, data_addr_ok}, (c == 3) ? 32'b01 : 32'b00);
            tick();
        end
        data_req = 0; inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h5;
        settle();
        chk("t2_rsp", {30'b0, inst_data_ok, data_data_ok}, 32'b01);
        tick();
        mem_data_ok = 0;

        // inst hold freezes grant against a later data request
        inst_req = 1; inst_addr = 32'h1C000020; data_wr = 0; data_addr = 32'h300;
        settle();
        chk("t3_hold_i_addr", mem_addr, 32'h1C000020);
        tick();
        data_req = 1;
        settle();
        chk("t3_frozen_addr", mem_addr, 32'h1C000020);
        chk("t3_frozen_ok", {30'b0, inst_addr_ok, data_addr_ok}, 0);
        tick();
        mem_addr_ok = 1;
        settle();
        chk("t3_hold_acc", {30'b0, inst_addr_ok, data_addr_ok}, 32'b10);
        tick();
        inst_req = 0;
        settle();
        chk("t3_data_acc", {30'b0, inst_addr_ok, data_addr_ok}, 32'b01);
        tick();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        settle();
        chk("t3_rsp_i", {30'b0, inst_data_ok, data_data_ok}, 32'b10);
        tick();
        settle();
        chk("t3_rsp_d", {30'b0, inst_data_ok, data_data_ok}, 32'b01);
        tick();
        mem_data_ok = 0;

        // requester drop in HOLD releases the lock
        inst_req = 1;
        settle();
        tick();
        inst_req = 0; data_req = 1;
        settle();
        chk("t4_drop_req", 32'(mem_req), 0);
        tick();
        mem_addr_ok = 1;
        settle();
        chk("t4_after_drop", {mem_req, inst_addr_ok, data_addr_ok}, 32'b101);
        tick();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        settle();
        chk("t4_rsp", {30'b0, inst_data_ok, data_data_ok}, 32'b01);
        tick();
        mem_data_ok = 0;

        // full blocks a 3rd issue, even on a same-cycle pop
        inst_req = 1; inst_addr = 32'h1C000004; mem_addr_ok = 1;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk("t5_fill_ok", 32'(inst_addr_ok), 1);
            tick();
        end
        settle();
        chk("t5_full_req", {mem_req, inst_addr_ok}, 0);
        tick();
        mem_data_ok = 1; mem_rdata = 32'h77;
        settle();
        chk("t5_pop_full", {mem_req, inst_data_ok, inst_addr_ok}, 32'b010);
        tick();
        mem_data_ok = 0;
        settle();
        chk("t5_reissue", {mem_req, inst_addr_ok}, 32'b11);
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        tick(); tick();
        mem_data_ok = 0;

        // push+pop at count 1 across pointer wrap, owner order D,I,I,D,I
        owners = 5'b01001;
        mem_addr_ok = 1;
        for (int k = 0; k < 6; k++) begin
            inst_req = (k < 5) && !owners[k];
            data_req = (k < 5) && owners[k];
            mem_data_ok = (k > 0);
            mem_rdata = 32'(k);
            settle();
            if (k < 5) chk("t6_push", {mem_req, inst_addr_ok, data_addr_ok}, {1'b1, !owners[k], owners[k]});
            if (k > 0) chk("t6_pop", {inst_data_ok, data_data_ok}, {!owners[k-1], owners[k-1]});
            tick();
        end
        inst_req = 0; data_req = 0; mem_data_ok = 0;

        // reset with 2 outstanding flushes the FIFO; late responses dropped
        inst_req = 1;
        tick(); tick();
        inst_req = 0; mem_addr_ok = 0; reset = 1;
        tick();
        reset = 0; mem_data_ok = 1;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk("t7_late_rsp", {30'b0, inst_data_ok, data_data_ok}, 0);
            tick();
        end
        mem_data_ok = 0; inst_req = 1; mem_addr_ok = 1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("t7_count0", 32'(inst_addr_ok), (c < 2) ? 1 : 0);
            tick();
        end
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        tick(); tick();
        mem_data_ok = 0;

        // continuous tie: grants alternate under round-robin, else data always wins
        inst_req = 1; data_req = 1; mem_addr_ok = 1;
        for (int c = 0; c < 4; c++) begin
            mem_data_ok = (c > 0);
            settle();
`ifdef ARB_ROUND_ROBIN_EN
            chk("t8_rr_grant", {30'b0, inst_addr_ok, data_addr_ok}, (c % 2 == 0) ? 32'b01 : 32'b10);
`else
            chk("t8_fixed_grant", {30'b0, inst_addr_ok, data_addr_ok}, 32'b01);
`endif
            tick();
        end
        inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
